// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - packs N weight words and commits them to the convolver weight register
module weight_loader #(
    parameter int N          = 9,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = $clog2(N)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    input  logic                    conv_busy,
    output logic                    busy,
    output logic                    write,
    output logic [N*DATA_WIDTH-1:0] weight_write
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, COMMIT} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(N - 1);

    state_t               state;
    state_t               next_state;
    logic [CNT_WIDTH-1:0] count;
    logic                 accept;
    logic                 last_word;

    assign in_ready  = (state == LOAD);
    assign accept    = in_valid && in_ready;
    assign last_word = accept && (count == LAST);

    // Next-state decode; the commit is parked in HOLD while the convolver is busy
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    if (last_word) next_state = conv_busy ? HOLD : COMMIT;
            HOLD:    if (!conv_busy) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register with busy/write registered from the upcoming state
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            write <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            write <= (next_state == COMMIT);
        end
    end

    // Word counter: cleared when a load starts, advanced on each accepted word
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if ((state == IDLE) && start) begin
            count <= '0;
        end else if (accept) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    // Shadow buffer doubles as the output vector; untouched slots keep old words
    always_ff @(posedge clock) begin
        if (!reset) begin
            weight_write <= '0;
        end else if (accept) begin
            for (int k = 0; k < N; k++) begin
                if (count == CNT_WIDTH'(k)) begin
                    weight_write[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - randomized self-checking bench for weight_loader
module tb_weight_loader;

    localparam int N  = 9;
    localparam int DW = 16;
    localparam int WW = N * DW;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          conv_busy;
    logic          busy;
    logic          write;
    logic [WW-1:0] weight_write;

    weight_loader #(.N(N), .DATA_WIDTH(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .conv_busy    (conv_busy),
        .busy         (busy),
        .write        (write),
        .weight_write (weight_write)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit started  = 0;

    // Reference: accepted words land in an array; a load is "collecting",
    // "waiting for the convolver" or "committing this cycle"
    bit            m_collect;
    bit            m_wait;
    bit            m_commit;
    int            m_cnt;
    logic [DW-1:0] m_words [N];
    int            last_acc_cyc = -1;

    int            n_writes    = 0;
    int            last_wr_cyc = -1;
    logic [WW-1:0] last_wr_data;

    function automatic logic [WW-1:0] m_packed();
        logic [WW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = m_words[k];
        return r;
    endfunction

    function automatic logic [WW-1:0] ramp(input logic [DW-1:0] base);
        logic [WW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = base + DW'(k);
        return r;
    endfunction

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference update on each rising edge from the inputs present at that edge
    always @(posedge clock) begin
        cyc++;
        started = 1;
        if (!reset) begin
            m_collect = 0;
            m_wait    = 0;
            m_commit  = 0;
            m_cnt     = 0;
            for (int k = 0; k < N; k++) m_words[k] = '0;
        end else if (m_commit) begin
            m_commit = 0;
        end else if (m_collect) begin
            if (in_valid) begin
                m_words[m_cnt] = in_data;
                m_cnt++;
                if (m_cnt == N) begin
                    m_collect    = 0;
                    last_acc_cyc = cyc;
                    if (conv_busy) m_wait = 1;
                    else           m_commit = 1;
                end
            end
        end else if (m_wait) begin
            if (!conv_busy) begin
                m_wait   = 0;
                m_commit = 1;
            end
        end else if (start) begin
            m_collect = 1;
            m_cnt     = 0;
        end
    end

    // Compare process, sampling mid-cycle
    always @(negedge clock) begin
        if (started) begin
            check("in_ready", in_ready, m_collect);
            check("busy", busy, m_collect | m_wait | m_commit);
            check("write", write, m_commit);
            if (m_commit) check("weight_write", weight_write, m_packed());
            if (write === 1'b1) begin
                n_writes++;
                last_wr_cyc  = cyc;
                last_wr_data = weight_write;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input bit with_valid);
        start    = 1;
        in_valid = with_valid;
        in_data  = 16'hDEAD;
        step();
        start    = 0;
        in_valid = 0;
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random; spur: word index at which start is pulsed
    task automatic feed(input logic [DW-1:0] base, input int vmode, input bit hold_busy,
                        input int words, input int spur);
        int idx = 0;
        int t   = 0;
        bit ph  = 1;
        conv_busy = hold_busy;
        while (idx < words && t < 300) begin
            case (vmode)
                0:       in_valid = 1;
                1:       in_valid = ph;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            ph      = !ph;
            in_data = base + DW'(idx);
            start   = (idx == spur) || (vmode == 2 && $urandom_range(0, 5) == 0);
            if (in_valid && in_ready) idx++;
            step();
            t++;
        end
        checks++;
        if (t >= 300) begin
            failures++;
            $display("FAIL feed_timeout actual=%0d required=%0d", idx, words);
        end
        in_valid = 0;
        start    = 0;
    endtask

    task automatic wait_write(input int w0, input int bound);
        int t = 0;
        while (n_writes == w0 && t < bound) begin
            step();
            t++;
        end
        checks++;
        if (n_writes == w0) begin
            failures++;
            $display("FAIL write_timeout actual=0 required=1");
        end
    endtask

    initial begin
        int w0;
        int rel;
        logic [DW-1:0] base;
        bit hb;

        reset = 0; start = 0; in_valid = 0; in_data = '0; conv_busy = 0;
        repeat (5) step();
        reset = 1;
        @(negedge clock);
        check("rst_write", write, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_weight_write", weight_write, 0);

        // Basic load
        w0 = n_writes;
        do_start(0);
        feed(16'h0001, 0, 0, 9, -1);
        wait_write(w0, 20);
        check("basic_latency", last_wr_cyc, last_acc_cyc);
        check("basic_data", last_wr_data, 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001);
        check("basic_model", m_packed(), 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001);
        @(negedge clock);
        check("basic_busy_after", busy, 0);
        repeat (3) step();
        check("basic_nwrites", n_writes - w0, 1);

        // Stalled upstream, with in_valid already high in the start cycle
        w0 = n_writes;
        do_start(1);
        feed(16'h0001, 1, 0, 9, -1);
        wait_write(w0, 20);
        check("stall_latency", last_wr_cyc, last_acc_cyc);
        check("stall_data", last_wr_data, 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001);
        repeat (3) step();
        check("stall_nwrites", n_writes - w0, 1);

        // Busy hold
        w0 = n_writes;
        do_start(0);
        feed(16'h0001, 0, 1, 9, -1);
        repeat (10) step();
        check("hold_no_write", n_writes - w0, 0);
        conv_busy = 0;
        rel = cyc;
        wait_write(w0, 20);
        check("hold_latency", last_wr_cyc, rel + 1);
        check("hold_data", last_wr_data, 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001);

        // Reset mid-load
        w0 = n_writes;
        do_start(0);
        feed(16'h1230, 0, 0, 4, -1);
        reset = 0;
        repeat (2) step();
        reset = 1;
        repeat (3) step();
        check("midrst_no_write", n_writes - w0, 0);
        do_start(0);
        feed(16'hA000, 0, 0, 9, -1);
        wait_write(w0, 20);
        check("midrst_data", last_wr_data, 144'hA008_A007_A006_A005_A004_A003_A002_A001_A000);
        check("midrst_model", m_packed(), 144'hA008_A007_A006_A005_A004_A003_A002_A001_A000);

        // Spurious starts in LOAD and HOLD
        w0 = n_writes;
        do_start(0);
        feed(16'h0B00, 0, 1, 9, 3);
        start = 1;
        step();
        start = 0;
        repeat (3) step();
        conv_busy = 0;
        wait_write(w0, 20);
        repeat (3) step();
        check("spur_nwrites", n_writes - w0, 1);
        check("spur_data", last_wr_data, 144'h0B08_0B07_0B06_0B05_0B04_0B03_0B02_0B01_0B00);

        // Randomized loads
        for (int it = 0; it < 20; it++) begin
            w0   = n_writes;
            base = DW'($urandom);
            hb   = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) step();
            do_start(1'($urandom_range(0, 1)));
            feed(base, 2, hb, 9, -1);
            if (hb) begin
                for (int j = $urandom_range(0, 6); j > 0; j--) begin
                    conv_busy = 1'($urandom_range(0, 1));
                    start     = 1'($urandom_range(0, 1));
                    step();
                end
                start = 0;
            end
            conv_busy = 0;
            wait_write(w0, 30);
            check("rand_data", last_wr_data, ramp(base));
            step();
            check("rand_nwrites", n_writes - w0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
